libhdl_gray_count: RTL and testbench
====================================

LIBHDL_GRAY_COUNT -- requirements
Module: libhdl_gray_count

Interface
REQ-001 Parameter W, default 32, counter width in bits; legal range 2..64.
REQ-002 Parameter INIT_VAL, default {W{1'b0}}, binary count value loaded by reset.
REQ-003 Parameter WRAP, default 1; 1 = modulo-2^W wrap-around, 0 = saturate at the terminal values.
REQ-004 Clocking: one clock; reset is synchronous and active-low.
REQ-005 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 i_rstn  input  1  synchronous reset, active-low.
REQ-007 i_en  input  1  count enable; advances the count by one step when high.
REQ-008 i_up  input  1  direction; 1 = increment, 0 = decrement; sampled only when i_en=1.
REQ-009 i_load  input  1  synchronous load strobe.
REQ-010 i_load_val  input  W  binary value taken on i_load.
REQ-011 o_count  output  W  registered binary count.
REQ-012 o_gray  output  W  registered Gray code of o_count; the CDC-safe source for a downstream synchronizer.
REQ-013 o_tc  output  1  registered terminal count; high when o_count is all-ones (i_up=1) or all-zeros (i_up=0).
REQ-014 o_wrap  output  1  one-cycle pulse; the count wrapped (WRAP=1) or a step was blocked at saturation (WRAP=0).
REQ-015 o_disc  output  1  one-cycle pulse; o_gray changed by more than one bit (load or reset).

Function
REQ-016 Per cycle, priority SHALL be: reset > i_load > i_en > hold.
REQ-017 A load SHALL set o_count = i_load_val on the next edge, independent of i_en and i_up.
REQ-018 An enabled step SHALL set o_count to o_count+1 (i_up=1) or o_count-1 (i_up=0), modulo 2^W.
REQ-019 With WRAP=1, an increment from all-ones SHALL yield zero, a decrement from zero SHALL yield all-ones, and o_wrap SHALL pulse in the cycle the wrapped value appears.
REQ-020 With WRAP=0, a step beyond all-ones or below zero SHALL hold the count and pulse o_wrap.
REQ-021 o_gray SHALL equal bin ^ (bin >> 1) of the same-cycle o_count; it SHALL be computed from the next-state binary value and registered, never decoded combinationally after the o_count flop.
REQ-022 Between consecutive cycles without load or reset, o_gray SHALL differ in at most one bit, including across wrap-around.
REQ-023 o_disc SHALL pulse in the cycle after a load whose Hamming distance in Gray code from the previous o_gray exceeds 1; it SHALL stay low for a load of an adjacent or equal value.
REQ-024 With i_en=0 and i_load=0, all outputs SHALL hold, and o_wrap and o_disc SHALL be 0.
REQ-025 o_tc SHALL reflect the registered count and the current i_up with one cycle of latency, as a flop output.
REQ-026 Latency from an input change to the corresponding o_count or o_gray change SHALL be exactly one clock.

Reset
REQ-027 When i_rstn=0 at an edge: o_count=INIT_VAL, o_gray=Gray(INIT_VAL), o_wrap=0, o_disc=1 for the first cycle after release, and o_tc is evaluated from INIT_VAL with i_up taken as 1.
REQ-028 Reset asserted during a count or load SHALL override both in the same edge; no partial update.

Structure
REQ-029 The bin2gray and gray2bin functions SHALL live in a shared function package (libhdl_gray_pkg) reused with the existing sync counter; this block SHALL NOT define local copies.
REQ-030 No sub-module is required; the next-state binary logic, Gray encoding and flag logic are flat within the block.

Verification
REQ-031 W=4, reset, then i_en=1, i_up=1 for 16 cycles -> o_count 0..15..0; o_gray always one-bit steps; o_wrap pulses once at 15->0.
REQ-032 W=4, WRAP=0, count down from 1 -> 0 then holds 0; o_wrap pulses each blocked cycle; o_tc=1.
REQ-033 Load 4'h9 from 4'h2 -> o_count=9 and o_gray=4'hD next cycle; o_disc=1 for one cycle.
REQ-034 Assert i_load and i_en together with load value 5 -> o_count=5; the step is ignored.
REQ-035 Assert i_rstn=0 during counting at 7 with INIT_VAL=3 -> o_count=3, o_gray=2 next edge; no o_wrap.
REQ-036 Random i_en/i_up/i_load for 10k cycles -> scoreboard matches o_count; o_gray==Gray(o_count) every cycle; at most one bit changes whenever o_disc=0.

Source files
------------

// File: rtl/libhdl_gray_pkg.sv
// Shared Gray-code helpers for the counter blocks.
// Functions work on 64 bits; narrower callers zero-extend.
package libhdl_gray_pkg;

  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] bin2gray(
    input logic [MAX_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_W-1:0] gray2bin(
    input logic [MAX_W-1:0] g
  );
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/libhdl_gray_count.sv
// Up/down binary counter with registered Gray output,
// terminal-count, wrap/saturate and discontinuity flags.
module libhdl_gray_count
  import libhdl_gray_pkg::*;
#(
  parameter int          W        = 32,
  parameter logic [W-1:0] INIT_VAL = '0,
  parameter bit          WRAP     = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_en,
  input  logic         i_up,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_gray,
  output logic         o_tc,
  output logic         o_wrap,
  output logic         o_disc
);

  localparam logic [W-1:0] ONES = '1;
  localparam logic [W-1:0] ZERO = '0;
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] GRAY_INIT =
    W'(bin2gray(MAX_W'(INIT_VAL)));

  logic [W-1:0] cnt_q;
  logic [W-1:0] gray_q;
  logic         tc_q;
  logic         wrap_q;
  logic         disc_q;

  logic [W-1:0] cnt_d;
  logic [W-1:0] gray_d;
  logic [W-1:0] step_v;
  logic         at_end;
  logic         tc_d;
  logic         wrap_d;
  logic         disc_d;

  always_comb begin
    cnt_d  = cnt_q;
    tc_d   = tc_q;
    wrap_d = 1'b0;
    step_v = i_up ? cnt_q + ONE : cnt_q - ONE;
    at_end = i_up ? (cnt_q == ONES) : (cnt_q == ZERO);
    if (i_load) begin
      cnt_d = i_load_val;
      tc_d  = i_up ? (i_load_val == ONES)
                   : (i_load_val == ZERO);
    end else if (i_en) begin
      wrap_d = at_end;
      cnt_d  = (at_end && !WRAP) ? cnt_q : step_v;
      tc_d   = i_up ? (cnt_d == ONES) : (cnt_d == ZERO);
    end
  end

  // Gray is encoded from the next binary value so it leaves a flop.
  assign gray_d = W'(bin2gray(MAX_W'(cnt_d)));

  always_comb begin
    disc_d = 1'b0;
    if (i_load) begin
      disc_d = ($countones(gray_d ^ gray_q) > 1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      cnt_q  <= INIT_VAL;
      gray_q <= GRAY_INIT;
      tc_q   <= (INIT_VAL == ONES);
      wrap_q <= 1'b0;
      disc_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
      wrap_q <= wrap_d;
      disc_q <= disc_d;
    end
  end

  assign o_count = cnt_q;
  assign o_gray  = gray_q;
  assign o_tc    = tc_q;
  assign o_wrap  = wrap_q;
  assign o_disc  = disc_q;

endmodule

// File: tb/tb_libhdl_gray_count.sv
// Bench for libhdl_gray_count: wrapping (INIT 3) and saturating
// instances share stimulus and are checked against an integer model.
module tb_libhdl_gray_count;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic       i_en = 1'b0;
  logic       i_up = 1'b1;
  logic       i_load = 1'b0;
  logic [3:0] i_load_val = 4'h0;

  logic [3:0] a_count, a_gray, b_count, b_gray;
  logic       a_tc, a_wrap, a_disc, b_tc, b_wrap, b_disc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  libhdl_gray_count #(.W(4), .INIT_VAL(4'd3), .WRAP(1'b1)) dut_a (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_en(i_en), .i_up(i_up),
    .i_load(i_load), .i_load_val(i_load_val),
    .o_count(a_count), .o_gray(a_gray), .o_tc(a_tc),
    .o_wrap(a_wrap), .o_disc(a_disc)
  );

  libhdl_gray_count #(.W(4), .INIT_VAL(4'd0), .WRAP(1'b0)) dut_b (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_en(i_en), .i_up(i_up),
    .i_load(i_load), .i_load_val(i_load_val),
    .o_count(b_count), .o_gray(b_gray), .o_tc(b_tc),
    .o_wrap(b_wrap), .o_disc(b_disc)
  );

  // Behavioural model: plain integers, index 0 = wrapping, 1 = saturating.
  int m_cnt[2];
  bit m_tc[2], m_wrap[2], m_disc[2], m_valid[2];
  int m_init[2] = '{3, 0};
  bit m_wrapmode[2] = '{1'b1, 1'b0};

  function automatic int gray_of(input int x);
    return x ^ (x >> 1);
  endfunction

  always @(posedge i_clk) begin
    int n;
    for (int k = 0; k < 2; k++) begin
      if (!i_rstn) begin
        m_cnt[k]   <= m_init[k];
        m_tc[k]    <= (m_init[k] == 15);
        m_wrap[k]  <= 1'b0;
        m_disc[k]  <= 1'b1;
        m_valid[k] <= 1'b1;
      end else if (i_load) begin
        n = int'(i_load_val);
        m_disc[k] <= $countones(gray_of(n) ^ gray_of(m_cnt[k])) > 1;
        m_cnt[k]  <= n;
        m_wrap[k] <= 1'b0;
        m_tc[k]   <= i_up ? (n == 15) : (n == 0);
      end else if (i_en) begin
        n = m_cnt[k] + (i_up ? 1 : -1);
        m_disc[k] <= 1'b0;
        if (n > 15 || n < 0) begin
          m_wrap[k] <= 1'b1;
          n = m_wrapmode[k] ? (n & 15) : m_cnt[k];
        end else begin
          m_wrap[k] <= 1'b0;
        end
        m_cnt[k] <= n;
        m_tc[k]  <= i_up ? (n == 15) : (n == 0);
      end else begin
        m_wrap[k] <= 1'b0;
        m_disc[k] <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Per-cycle compare, plus the one-bit Gray step rule.
  int  prev_g[2];
  bit  prev_ok[2] = '{1'b0, 1'b0};

  task automatic cmp_inst(
    input int k, input logic [3:0] c, input logic [3:0] g,
    input logic tc, input logic wr, input logic ds
  );
    chk($sformatf("count[%0d]", k), int'(c), m_cnt[k]);
    chk($sformatf("gray[%0d]", k), int'(g), gray_of(m_cnt[k]));
    chk($sformatf("tc[%0d]", k), int'(tc), int'(m_tc[k]));
    chk($sformatf("wrap[%0d]", k), int'(wr), int'(m_wrap[k]));
    chk($sformatf("disc[%0d]", k), int'(ds), int'(m_disc[k]));
    if (prev_ok[k] && !ds) begin
      chk($sformatf("gray_step[%0d]", k),
          int'($countones(int'(g) ^ prev_g[k]) <= 1), 1);
    end
    prev_g[k]  = int'(g);
    prev_ok[k] = 1'b1;
  endtask

  always @(negedge i_clk) begin
    if (m_valid[0]) cmp_inst(0, a_count, a_gray, a_tc, a_wrap, a_disc);
    if (m_valid[1]) cmp_inst(1, b_count, b_gray, b_tc, b_wrap, b_disc);
  end

  task automatic cyc(
    input bit r, input bit e, input bit u, input bit l,
    input logic [3:0] v
  );
    i_rstn = r; i_en = e; i_up = u; i_load = l; i_load_val = v;
    @(posedge i_clk);
    #1;
  endtask

  int wa, wb;

  initial begin
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    chk("rst_a_count", a_count, 3);
    chk("rst_a_gray", a_gray, 2);
    chk("rst_a_disc", a_disc, 1);
    chk("rst_a_wrap", a_wrap, 0);
    chk("rst_b_tc", b_tc, 0);

    cyc(1, 0, 1, 1, 4'd0);
    chk("load0_disc", a_disc, 0);
    wa = 0; wb = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1, 1, 1, 0, 0);
      wa += int'(a_wrap);
      wb += int'(b_wrap);
    end
    chk("up16_a_count", a_count, 0);
    chk("up16_a_wraps", wa, 1);
    chk("up16_b_count", b_count, 15);
    chk("up16_b_wraps", wb, 1);
    chk("up16_b_tc", b_tc, 1);

    cyc(1, 0, 0, 1, 4'd1);
    cyc(1, 1, 0, 0, 0);
    chk("sat_b_count0", b_count, 0);
    chk("sat_b_wrap0", b_wrap, 0);
    chk("sat_b_tc0", b_tc, 1);
    cyc(1, 1, 0, 0, 0);
    chk("sat_b_count1", b_count, 0);
    chk("sat_b_wrap1", b_wrap, 1);
    cyc(1, 1, 0, 0, 0);
    chk("sat_b_wrap2", b_wrap, 1);
    chk("sat_b_tc2", b_tc, 1);

    cyc(1, 0, 1, 1, 4'd2);
    cyc(1, 0, 1, 1, 4'd9);
    chk("ld9_count", a_count, 9);
    chk("ld9_gray", a_gray, 13);
    chk("ld9_disc", a_disc, 1);
    cyc(1, 0, 1, 0, 0);
    chk("ld9_disc_clr", a_disc, 0);
    chk("hold_count", a_count, 9);

    cyc(1, 1, 1, 1, 4'd5);
    chk("ld_en_count", a_count, 5);

    cyc(1, 0, 1, 1, 4'd6);
    cyc(1, 1, 1, 0, 0);
    chk("cnt7", a_count, 7);
    cyc(0, 1, 1, 0, 0);
    chk("rst7_count", a_count, 3);
    chk("rst7_gray", a_gray, 2);
    chk("rst7_wrap", a_wrap, 0);

    for (int i = 0; i < 10000; i++) begin
      cyc($urandom_range(0, 199) != 0,
          $urandom_range(0, 3) != 0,
          1'($urandom),
          $urandom_range(0, 7) == 0,
          4'($urandom));
    end

    @(negedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
